// File: rtl/led_share_arbiter.sv
// Round-robin sharing of the 6-LED bank with tick-based hold and blanking gap; active-low LEDs.
// Optional macro LED_ARB_PREEMPT_EN makes requester 0 urgent (preempts other owners).
module led_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TICK_DIV   = 1048576,
  parameter int HOLD_TICKS = 4,
  parameter int GAP_TICKS  = 1
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic [NUM_REQ-1:0]   in_req,
  input  logic [6*NUM_REQ-1:0] in_pattern,
  output logic [NUM_REQ-1:0]   out_grant,
  output logic                 out_busy,
  output logic [5:0]           out_led
);

  localparam int PRESC_W   = $clog2(TICK_DIV);
  localparam int MAX_TICKS = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int HOLD_W    = $clog2(MAX_TICKS + 1);
  localparam int IDX_W     = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state, next_state;
  logic [PRESC_W-1:0]   presc, next_presc;
  logic [HOLD_W-1:0]    hold, next_hold;
  logic [IDX_W-1:0]     owner, next_owner;
  logic [IDX_W-1:0]     ptr, next_ptr;
  logic [NUM_REQ-1:0]   grant, next_grant;
  logic [5:0]           led, next_led;

  logic                 tick;
  logic                 any_req;
  logic [HOLD_W-1:0]    hold_inc;
  logic [PRESC_W-1:0]   presc_adv;
  logic [5:0]           owner_pattern;
  logic [IDX_W-1:0]     win;
  logic [IDX_W-1:0]     cand;
  logic                 found;
  logic                 preempt;

`ifdef LED_ARB_PREEMPT_EN
  logic                 pend, next_pend;
`endif

  assign tick          = (presc == PRESC_W'(TICK_DIV - 1));
  assign any_req       = |in_req;
  assign hold_inc      = hold + HOLD_W'(1);
  assign presc_adv     = tick ? '0 : presc + PRESC_W'(1);
  assign owner_pattern = in_pattern[6*int'(owner) +: 6];

  // Winner: first requester above the pointer, wrapping; a preempting requester 0 jumps the queue.
  always_comb begin
    win   = ptr;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && in_req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
`ifdef LED_ARB_PREEMPT_EN
    if (pend && in_req[0]) win = '0;
`endif
  end

`ifdef LED_ARB_PREEMPT_EN
  assign preempt = (owner != '0) && in_req[0];
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    next_state = state;
    next_presc = presc;
    next_hold  = hold;
    next_owner = owner;
    next_ptr   = ptr;
    next_grant = grant;
    next_led   = led;
`ifdef LED_ARB_PREEMPT_EN
    next_pend  = pend;
`endif
    case (state)
      IDLE: begin
        next_presc = '0;
        next_hold  = '0;
        next_led   = 6'h3F;
        if (any_req) begin
          next_state = GRANT;
          next_grant = NUM_REQ'(1) << win;
          next_owner = win;
          next_ptr   = win;
`ifdef LED_ARB_PREEMPT_EN
          next_pend  = 1'b0;
`endif
        end
      end
      GRANT: begin
        next_led   = ~owner_pattern;
        next_presc = presc_adv;
        if (tick) next_hold = hold_inc;
        // Release, preemption and hold expiry all fall into the same blanking gap.
        if (!in_req[owner] || preempt || (tick && hold_inc == HOLD_W'(HOLD_TICKS))) begin
          next_state = GAP;
          next_grant = '0;
          next_led   = 6'h3F;
          next_presc = '0;
          next_hold  = '0;
`ifdef LED_ARB_PREEMPT_EN
          next_pend  = preempt;
`endif
        end
      end
      GAP: begin
        next_led   = 6'h3F;
        next_presc = presc_adv;
        if (tick) begin
          if (hold_inc == HOLD_W'(GAP_TICKS)) begin
            next_hold  = '0;
            next_presc = '0;
            if (any_req) begin
              next_state = GRANT;
              next_grant = NUM_REQ'(1) << win;
              next_owner = win;
              next_ptr   = win;
`ifdef LED_ARB_PREEMPT_EN
              next_pend  = 1'b0;
`endif
            end else begin
              next_state = IDLE;
            end
          end else begin
            next_hold = hold_inc;
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_grant = '0;
        next_led   = 6'h3F;
        next_presc = '0;
        next_hold  = '0;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= IDLE;
      presc <= '0;
      hold  <= '0;
      owner <= '0;
      ptr   <= IDX_W'(NUM_REQ - 1);
      grant <= '0;
      led   <= 6'h3F;
`ifdef LED_ARB_PREEMPT_EN
      pend  <= 1'b0;
`endif
    end else begin
      state <= next_state;
      presc <= next_presc;
      hold  <= next_hold;
      owner <= next_owner;
      ptr   <= next_ptr;
      grant <= next_grant;
      led   <= next_led;
`ifdef LED_ARB_PREEMPT_EN
      pend  <= next_pend;
`endif
    end
  end

  assign out_grant = grant;
  assign out_busy  = (state != IDLE);
  assign out_led   = led;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter (NUM_REQ=4, TICK_DIV=4, HOLD_TICKS=2, GAP_TICKS=1).
// Preemption expectations follow LED_ARB_PREEMPT_EN when it is defined for the build.
module tb_led_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [23:0] pattern;
  logic [3:0]  grant;
  logic        busy;
  logic [5:0]  led;

  int tests_run    = 0;
  int tests_failed = 0;

  led_share_arbiter #(
    .NUM_REQ(4), .TICK_DIV(4), .HOLD_TICKS(2), .GAP_TICKS(1)
  ) dut (
    .in_clk(clk),
    .in_rst_n(rst_n),
    .in_req(req),
    .in_pattern(pattern),
    .out_grant(grant),
    .out_busy(busy),
    .out_led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [23:0] p);
    req     = r;
    pattern = p;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  logic [3:0] rr_order [5];

  initial begin
    rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0;
    applyStimulus(4'b0000, {6'h33, 6'h0A, 6'h15, 6'h01});
    cyc();
    cyc();
    checkOutput("reset_grant", 32'(grant), 32'h0);
    checkOutput("reset_led", 32'(led), 32'h3F);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    cyc();
    checkOutput("idle_busy", 32'(busy), 32'h0);

    // Single requester: grant, pattern latency, 8-cycle hold, 4-cycle gap, regrant
    applyStimulus(4'b0010, {6'h33, 6'h0A, 6'h15, 6'h01});
    cyc();
    checkOutput("single_grant", 32'(grant), 32'h2);
    checkOutput("single_led_blank", 32'(led), 32'h3F);
    checkOutput("single_busy", 32'(busy), 32'h1);
    cyc();
    checkOutput("single_led", 32'(led), 32'h2A);
    repeat (6) cyc();
    checkOutput("single_last_cycle", 32'(grant), 32'h2);
    cyc();
    checkOutput("single_gap_grant", 32'(grant), 32'h0);
    checkOutput("single_gap_led", 32'(led), 32'h3F);
    checkOutput("single_gap_busy", 32'(busy), 32'h1);
    repeat (3) cyc();
    checkOutput("single_gap_end", 32'(grant), 32'h0);
    cyc();
    checkOutput("single_regrant", 32'(grant), 32'h2);

    // Release straight after regrant; no requests remain so the gap ends in IDLE
    applyStimulus(4'b0000, pattern);
    cyc();
    checkOutput("release_grant", 32'(grant), 32'h0);
    repeat (3) cyc();
    checkOutput("release_gap_busy", 32'(busy), 32'h1);
    cyc();
    checkOutput("release_idle_busy", 32'(busy), 32'h0);

    // Pointer sits at 1, so all-request picks 2; then reset mid-grant
    applyStimulus(4'b1111, pattern);
    cyc();
    checkOutput("rr_from_ptr1", 32'(grant), 32'h4);
    cyc();
    checkOutput("rr_led2", 32'(led), 32'h35);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_grant", 32'(grant), 32'h0);
    checkOutput("async_rst_led", 32'(led), 32'h3F);
    checkOutput("async_rst_busy", 32'(busy), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Full round-robin rotation after reset
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("rr_grant%0d", i), 32'(grant), 32'(rr_order[i]));
      if (i < 4) begin
        repeat (7) cyc();
        checkOutput($sformatf("rr_hold%0d", i), 32'(grant), 32'(rr_order[i]));
        cyc();
        checkOutput($sformatf("rr_gap_start%0d", i), 32'(grant), 32'h0);
        repeat (3) cyc();
        checkOutput($sformatf("rr_gap_end%0d", i), 32'(led), 32'h3F);
        cyc();
      end
    end

    // Pattern tracking on requester 0
    applyStimulus(4'b0001, pattern);
    cyc();
    checkOutput("track_led_a", 32'(led), 32'h3E);
    applyStimulus(4'b0001, {6'h33, 6'h0A, 6'h15, 6'h3E});
    cyc();
    checkOutput("track_led_b", 32'(led), 32'h01);
    applyStimulus(4'b0001, {6'h33, 6'h2C, 6'h15, 6'h3E});
    cyc();
    checkOutput("track_nonowner", 32'(led), 32'h01);

    // Owner 0 releases, requester 2 takes over after the gap, then releases early
    applyStimulus(4'b0100, pattern);
    cyc();
    checkOutput("handoff_gap", 32'(grant), 32'h0);
    repeat (3) cyc();
    checkOutput("handoff_gap_end", 32'(grant), 32'h0);
    cyc();
    checkOutput("handoff_grant2", 32'(grant), 32'h4);
    cyc();
    checkOutput("handoff_led2", 32'(led), 32'h13);
    cyc();
    applyStimulus(4'b0000, pattern);
    cyc();
    checkOutput("early_release", 32'(grant), 32'h0);
    checkOutput("early_release_busy", 32'(busy), 32'h1);
    repeat (3) cyc();
    checkOutput("early_gap_busy", 32'(busy), 32'h1);
    cyc();
    checkOutput("early_idle_busy", 32'(busy), 32'h0);
    checkOutput("early_idle_led", 32'(led), 32'h3F);

    // Requester 3 owns while requester 0 raises its request
    applyStimulus(4'b1000, pattern);
    cyc();
    checkOutput("own3_grant", 32'(grant), 32'h8);
    cyc();
    checkOutput("own3_led", 32'(led), 32'h0C);
    cyc();
    applyStimulus(4'b1001, pattern);
`ifdef LED_ARB_PREEMPT_EN
    cyc();
    checkOutput("preempt_gap", 32'(grant), 32'h0);
    checkOutput("preempt_busy", 32'(busy), 32'h1);
    repeat (3) cyc();
    checkOutput("preempt_gap_end", 32'(grant), 32'h0);
    cyc();
    checkOutput("preempt_grant0", 32'(grant), 32'h1);
`else
    repeat (5) cyc();
    checkOutput("nopreempt_hold", 32'(grant), 32'h8);
    cyc();
    checkOutput("nopreempt_gap", 32'(grant), 32'h0);
    repeat (4) cyc();
    checkOutput("nopreempt_next0", 32'(grant), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
